// File: rtl/sram_arbiter.sv
// -----------------------------------------------------------------------------
// sram_arbiter
//
// Shares one sram-like downstream bus between an instruction-fetch port and a
// load-store port. Requests are forwarded combinationally (zero added latency)
// and responses are routed back using a small FIFO of owner tags, which relies
// on the downstream returning responses strictly in acceptance order.
//
// Ports:
//   clk, resetn                     clock, synchronous active-low reset
//   inst_sram_*                     fetch request in, addr_ok/data_ok/rdata out
//   data_sram_*                     load-store request in, addr_ok/data_ok/rdata out
//   bus_req/wr/size/wstrb/addr/wdata  forwarded request to the downstream bus
//   bus_addr_ok/data_ok/rdata       downstream handshake and read data
//
// Parameter:
//   OT_DEPTH  max accepted-but-unanswered downstream transactions (power of 2, >=2)
// -----------------------------------------------------------------------------
module sram_arbiter #(
   parameter int OT_DEPTH = 2
) (
   input  logic        clk,
   input  logic        resetn,

   input  logic        inst_sram_req,
   input  logic [1:0]  inst_sram_size,
   input  logic [31:0] inst_sram_addr,
   output logic        inst_sram_addr_ok,
   output logic        inst_sram_data_ok,
   output logic [31:0] inst_sram_rdata,

   input  logic        data_sram_req,
   input  logic        data_sram_wr,
   input  logic [1:0]  data_sram_size,
   input  logic [3:0]  data_sram_wstrb,
   input  logic [31:0] data_sram_addr,
   input  logic [31:0] data_sram_wdata,
   output logic        data_sram_addr_ok,
   output logic        data_sram_data_ok,
   output logic [31:0] data_sram_rdata,

   output logic        bus_req,
   output logic        bus_wr,
   output logic [1:0]  bus_size,
   output logic [3:0]  bus_wstrb,
   output logic [31:0] bus_addr,
   output logic [31:0] bus_wdata,
   input  logic        bus_addr_ok,
   input  logic        bus_data_ok,
   input  logic [31:0] bus_rdata
);

   localparam int PTR_W = $clog2(OT_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(OT_DEPTH);

   typedef enum logic {
      IDLE,
      LOCK
   } state_t;

   state_t              state_q;
   state_t              state_d;
   logic                owner_q;
   logic                owner_d;

   logic [CNT_W-1:0]    count_q;
   logic [PTR_W-1:0]    rd_ptr_q;
   logic [PTR_W-1:0]    wr_ptr_q;
   logic [OT_DEPTH-1:0] tag_q;

   logic                fifo_full;
   logic                fifo_empty;
   logic                grant_valid;
   logic                grant_owner;
   logic                push;
   logic                pop;
   logic                head_tag;

   assign fifo_full  = (count_q == FULL_COUNT);
   assign fifo_empty = (count_q == '0);

   // Grant state register. owner_q only matters in LOCK, where it pins the bus
   // to the port whose request was presented but not yet accepted.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q <= IDLE;
         owner_q <= 1'b0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
      end
   end

   // Next-state logic: a presented request that is not accepted locks the bus
   // to its owner so the request stays stable until the downstream takes it.
   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      case (state_q)
         IDLE: begin
            if (grant_valid && !bus_addr_ok) begin
               state_d = LOCK;
               owner_d = grant_owner;
            end
         end
         LOCK: begin
            if (bus_addr_ok) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Output logic: select the granted port (data has priority when unlocked),
   // forward its request to the bus and return addr_ok only to that port.
   // A full tag FIFO blocks all forwarding; LOCK is never entered while full.
   always_comb begin
      grant_valid = 1'b0;
      grant_owner = 1'b0;
      if (!fifo_full) begin
         if (state_q == LOCK) begin
            grant_valid = 1'b1;
            grant_owner = owner_q;
         end else if (data_sram_req) begin
            grant_valid = 1'b1;
            grant_owner = 1'b1;
         end else if (inst_sram_req) begin
            grant_valid = 1'b1;
            grant_owner = 1'b0;
         end
      end

      bus_req   = grant_valid;
      bus_wr    = 1'b0;
      bus_size  = 2'b00;
      bus_wstrb = 4'b0000;
      bus_addr  = 32'h0;
      bus_wdata = 32'h0;
      if (grant_valid) begin
         if (grant_owner) begin
            bus_wr    = data_sram_wr;
            bus_size  = data_sram_size;
            bus_wstrb = data_sram_wstrb;
            bus_addr  = data_sram_addr;
            bus_wdata = data_sram_wdata;
         end else begin
            bus_size  = inst_sram_size;
            bus_addr  = inst_sram_addr;
         end
      end

      inst_sram_addr_ok = bus_addr_ok & grant_valid & ~grant_owner;
      data_sram_addr_ok = bus_addr_ok & grant_valid &  grant_owner;
   end

   assign push = grant_valid & bus_addr_ok;
   // A response with nothing outstanding is stray and must not underflow.
   assign pop  = bus_data_ok & ~fifo_empty;

   // Outstanding-transaction tag FIFO. Pointers wrap naturally because the
   // depth is a power of two; simultaneous push and pop leave the count alone.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         count_q  <= '0;
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         tag_q    <= '0;
      end else begin
         if (push) begin
            tag_q[wr_ptr_q] <= grant_owner;
            wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         end
         case ({push, pop})
            2'b10:   count_q <= count_q + CNT_W'(1);
            2'b01:   count_q <= count_q - CNT_W'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   assign head_tag = tag_q[rd_ptr_q];

   assign inst_sram_data_ok = bus_data_ok & ~fifo_empty & ~head_tag;
   assign data_sram_data_ok = bus_data_ok & ~fifo_empty &  head_tag;
   assign inst_sram_rdata   = bus_rdata;
   assign data_sram_rdata   = bus_rdata;

endmodule

// File: tb/tb_sram_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sram_arbiter
//
// Self-checking bench for sram_arbiter. Inputs change on the falling edge and
// outputs are compared one time unit later against a reference model built
// from a "locked owner" value and a queue of outstanding owner tags. Directed
// scenarios come first, followed by a randomized phase with random reset pulses.
// -----------------------------------------------------------------------------
module tb_sram_arbiter;

   localparam int OT_DEPTH = 2;

   logic        clk = 1'b0;
   logic        resetn;

   logic        inst_sram_req;
   logic [1:0]  inst_sram_size;
   logic [31:0] inst_sram_addr;
   logic        inst_sram_addr_ok;
   logic        inst_sram_data_ok;
   logic [31:0] inst_sram_rdata;

   logic        data_sram_req;
   logic        data_sram_wr;
   logic [1:0]  data_sram_size;
   logic [3:0]  data_sram_wstrb;
   logic [31:0] data_sram_addr;
   logic [31:0] data_sram_wdata;
   logic        data_sram_addr_ok;
   logic        data_sram_data_ok;
   logic [31:0] data_sram_rdata;

   logic        bus_req;
   logic        bus_wr;
   logic [1:0]  bus_size;
   logic [3:0]  bus_wstrb;
   logic [31:0] bus_addr;
   logic [31:0] bus_wdata;
   logic        bus_addr_ok;
   logic        bus_data_ok;
   logic [31:0] bus_rdata;

   int errors = 0;
   int checks = 0;

   // Reference model state: -1 = no locked owner, 0 = inst, 1 = data.
   int locked_m = -1;
   bit ot_m[$];

   logic        exp_req, exp_owner, exp_wr;
   logic [1:0]  exp_size;
   logic [3:0]  exp_wstrb;
   logic [31:0] exp_addr, exp_wdata;
   logic        exp_iaok, exp_daok, exp_idok, exp_ddok;
   logic        last_iaok, last_daok;

   always #5 clk = ~clk;

   sram_arbiter #(.OT_DEPTH(OT_DEPTH)) dut (
      .clk               (clk),
      .resetn            (resetn),
      .inst_sram_req     (inst_sram_req),
      .inst_sram_size    (inst_sram_size),
      .inst_sram_addr    (inst_sram_addr),
      .inst_sram_addr_ok (inst_sram_addr_ok),
      .inst_sram_data_ok (inst_sram_data_ok),
      .inst_sram_rdata   (inst_sram_rdata),
      .data_sram_req     (data_sram_req),
      .data_sram_wr      (data_sram_wr),
      .data_sram_size    (data_sram_size),
      .data_sram_wstrb   (data_sram_wstrb),
      .data_sram_addr    (data_sram_addr),
      .data_sram_wdata   (data_sram_wdata),
      .data_sram_addr_ok (data_sram_addr_ok),
      .data_sram_data_ok (data_sram_data_ok),
      .data_sram_rdata   (data_sram_rdata),
      .bus_req           (bus_req),
      .bus_wr            (bus_wr),
      .bus_size          (bus_size),
      .bus_wstrb         (bus_wstrb),
      .bus_addr          (bus_addr),
      .bus_wdata         (bus_wdata),
      .bus_addr_ok       (bus_addr_ok),
      .bus_data_ok       (bus_data_ok),
      .bus_rdata         (bus_rdata)
   );

   // One comparison: counts it, and on mismatch counts and reports the failure.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   // Expected outputs for the current inputs, from the arbitration rules.
   task automatic computeExpected();
      exp_req   = 1'b0;
      exp_owner = 1'b0;
      if (ot_m.size() < OT_DEPTH) begin
         if (locked_m >= 0) begin
            exp_req   = 1'b1;
            exp_owner = (locked_m == 1);
         end else if (data_sram_req) begin
            exp_req   = 1'b1;
            exp_owner = 1'b1;
         end else if (inst_sram_req) begin
            exp_req   = 1'b1;
            exp_owner = 1'b0;
         end
      end
      exp_wr    = exp_req && exp_owner && data_sram_wr;
      exp_size  = !exp_req ? 2'b00 : (exp_owner ? data_sram_size : inst_sram_size);
      exp_wstrb = (exp_req && exp_owner) ? data_sram_wstrb : 4'b0000;
      exp_addr  = !exp_req ? 32'h0 : (exp_owner ? data_sram_addr : inst_sram_addr);
      exp_wdata = (exp_req && exp_owner) ? data_sram_wdata : 32'h0;
      exp_iaok  = bus_addr_ok && exp_req && !exp_owner;
      exp_daok  = bus_addr_ok && exp_req &&  exp_owner;
      exp_idok  = bus_data_ok && (ot_m.size() > 0) && (ot_m[0] == 1'b0);
      exp_ddok  = bus_data_ok && (ot_m.size() > 0) && (ot_m[0] == 1'b1);
   endtask

   // Let the current inputs settle, then compare every output with the model.
   task automatic applyStimulus();
      #1;
      computeExpected();
      checkOutput("bus_req",      bus_req,           exp_req);
      checkOutput("bus_wr",       bus_wr,            exp_wr);
      checkOutput("bus_size",     bus_size,          exp_size);
      checkOutput("bus_wstrb",    bus_wstrb,         exp_wstrb);
      checkOutput("bus_addr",     bus_addr,          exp_addr);
      checkOutput("bus_wdata",    bus_wdata,         exp_wdata);
      checkOutput("inst_addr_ok", inst_sram_addr_ok, exp_iaok);
      checkOutput("data_addr_ok", data_sram_addr_ok, exp_daok);
      checkOutput("inst_data_ok", inst_sram_data_ok, exp_idok);
      checkOutput("data_data_ok", data_sram_data_ok, exp_ddok);
      checkOutput("inst_rdata",   inst_sram_rdata,   bus_rdata);
      checkOutput("data_rdata",   data_sram_rdata,   bus_rdata);
   endtask

   // Advance one clock: update the model with what happened at the edge, then
   // return to the falling edge where the next inputs are driven.
   task automatic tick();
      @(posedge clk);
      last_iaok = exp_iaok;
      last_daok = exp_daok;
      if (!resetn) begin
         locked_m = -1;
         ot_m.delete();
      end else begin
         if (bus_data_ok && ot_m.size() > 0) void'(ot_m.pop_front());
         if (exp_req && bus_addr_ok) ot_m.push_back(exp_owner);
         if (exp_req) locked_m = bus_addr_ok ? -1 : (exp_owner ? 1 : 0);
      end
      @(negedge clk);
   endtask

   task automatic clearInputs();
      inst_sram_req   = 1'b0;
      inst_sram_size  = 2'd0;
      inst_sram_addr  = 32'h0;
      data_sram_req   = 1'b0;
      data_sram_wr    = 1'b0;
      data_sram_size  = 2'd0;
      data_sram_wstrb = 4'h0;
      data_sram_addr  = 32'h0;
      data_sram_wdata = 32'h0;
      bus_addr_ok     = 1'b0;
      bus_data_ok     = 1'b0;
      bus_rdata       = 32'h0;
   endtask

   initial begin
      clearInputs();
      resetn    = 1'b0;
      last_iaok = 1'b0;
      last_daok = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);

      // Held in reset with a stray response: nothing may leak out.
      bus_data_ok = 1'b1;
      applyStimulus();
      checkOutput("rst_bus_req", bus_req, 1'b0);
      checkOutput("rst_ddok", data_sram_data_ok, 1'b0);
      tick();
      bus_data_ok = 1'b0;
      resetn      = 1'b1;
      applyStimulus();
      checkOutput("post_rst_bus_req", bus_req, 1'b0);
      tick();

      // Simultaneous requests: data wins, inst follows next cycle.
      data_sram_req  = 1'b1;  data_sram_size = 2'd2;  data_sram_addr = 32'h100;
      inst_sram_req  = 1'b1;  inst_sram_size = 2'd2;  inst_sram_addr = 32'h200;
      bus_addr_ok    = 1'b1;
      applyStimulus();
      checkOutput("prio_addr", bus_addr, 32'h100);
      checkOutput("prio_daok", data_sram_addr_ok, 1'b1);
      checkOutput("prio_iaok", inst_sram_addr_ok, 1'b0);
      tick();
      data_sram_req = 1'b0;
      applyStimulus();
      checkOutput("second_addr", bus_addr, 32'h200);
      checkOutput("second_iaok", inst_sram_addr_ok, 1'b1);
      tick();
      inst_sram_req = 1'b0;
      data_sram_req = 1'b1;  data_sram_addr = 32'h104;
      applyStimulus();
      checkOutput("full_block", bus_req, 1'b0);
      tick();
      data_sram_req = 1'b0;  bus_data_ok = 1'b1;  bus_rdata = 32'hAAAA0001;
      applyStimulus();
      checkOutput("drain1_ddok", data_sram_data_ok, 1'b1);
      checkOutput("drain1_idok", inst_sram_data_ok, 1'b0);
      tick();
      bus_rdata = 32'hAAAA0002;
      applyStimulus();
      checkOutput("drain2_idok", inst_sram_data_ok, 1'b1);
      tick();
      bus_data_ok = 1'b0;

      // Fill with inst then data; bus stalls while full and resumes after one response.
      inst_sram_req = 1'b1;  inst_sram_addr = 32'h300;  bus_addr_ok = 1'b1;
      applyStimulus();  tick();
      inst_sram_req = 1'b0;
      data_sram_req = 1'b1;  data_sram_addr = 32'h108;
      applyStimulus();  tick();
      data_sram_addr = 32'h10c;
      for (int i = 0; i < 2; i++) begin
         applyStimulus();
         checkOutput("stall_req", bus_req, 1'b0);
         tick();
      end
      bus_data_ok = 1'b1;  bus_rdata = 32'h0BAD_F00D;
      applyStimulus();
      checkOutput("stall_idok", inst_sram_data_ok, 1'b1);
      checkOutput("stall_still_full", bus_req, 1'b0);
      tick();
      bus_data_ok = 1'b0;
      applyStimulus();
      checkOutput("resume_req", bus_req, 1'b1);
      checkOutput("resume_addr", bus_addr, 32'h10c);
      tick();
      data_sram_req = 1'b0;  bus_data_ok = 1'b1;
      for (int i = 0; i < 2; i++) begin
         applyStimulus();
         checkOutput("resume_drain_ddok", data_sram_data_ok, 1'b1);
         tick();
      end
      bus_data_ok = 1'b0;

      // Unaccepted inst request locks the bus even after data starts requesting.
      inst_sram_req = 1'b1;  inst_sram_addr = 32'h400;  bus_addr_ok = 1'b0;
      for (int c = 0; c < 3; c++) begin
         if (c == 1) begin
            data_sram_req = 1'b1;  data_sram_addr = 32'h500;
         end
         applyStimulus();
         checkOutput("lock_addr", bus_addr, 32'h400);
         checkOutput("lock_daok", data_sram_addr_ok, 1'b0);
         tick();
      end
      bus_addr_ok = 1'b1;
      applyStimulus();
      checkOutput("lock_accept_iaok", inst_sram_addr_ok, 1'b1);
      checkOutput("lock_accept_daok", data_sram_addr_ok, 1'b0);
      tick();
      inst_sram_req = 1'b0;
      applyStimulus();
      checkOutput("after_lock_addr", bus_addr, 32'h500);
      checkOutput("after_lock_daok", data_sram_addr_ok, 1'b1);
      tick();
      data_sram_req = 1'b0;  bus_addr_ok = 1'b0;  bus_data_ok = 1'b1;
      applyStimulus();  tick();
      applyStimulus();  tick();
      bus_data_ok = 1'b0;

      // Full-word store is forwarded intact and answered on the data port only.
      inst_sram_req   = 1'b1;  inst_sram_addr = 32'h600;
      data_sram_req   = 1'b1;  data_sram_wr = 1'b1;  data_sram_size = 2'd2;
      data_sram_wstrb = 4'b1111;  data_sram_addr = 32'h1c;  data_sram_wdata = 32'h12345678;
      bus_addr_ok     = 1'b1;
      applyStimulus();
      checkOutput("store_wr", bus_wr, 1'b1);
      checkOutput("store_wdata", bus_wdata, 32'h12345678);
      tick();
      data_sram_req = 1'b0;  data_sram_wr = 1'b0;  inst_sram_req = 1'b0;
      bus_data_ok   = 1'b1;
      applyStimulus();
      checkOutput("store_ddok", data_sram_data_ok, 1'b1);
      checkOutput("store_idok", inst_sram_data_ok, 1'b0);
      tick();
      bus_data_ok = 1'b0;

      // Steady push+pop across pointer wrap, owners alternating every cycle.
      inst_sram_req = 1'b1;  inst_sram_addr = 32'h700;  bus_addr_ok = 1'b1;
      applyStimulus();  tick();
      bus_data_ok = 1'b1;
      for (int k = 0; k < 8; k++) begin
         inst_sram_req  = k[0];
         data_sram_req  = !k[0];
         inst_sram_addr = 32'h800 + 32'(k * 4);
         data_sram_addr = 32'h900 + 32'(k * 4);
         applyStimulus();
         checkOutput("wrap_idok", inst_sram_data_ok, (k == 0) ? 1'b1 : !k[0]);
         checkOutput("wrap_ddok", data_sram_data_ok, (k == 0) ? 1'b0 : k[0]);
         tick();
      end
      inst_sram_req = 1'b0;  data_sram_req = 1'b0;  bus_addr_ok = 1'b0;
      applyStimulus();  tick();
      bus_data_ok = 1'b0;

      // Reset with two outstanding; a late response afterwards is discarded.
      inst_sram_req = 1'b1;  data_sram_req = 1'b1;  bus_addr_ok = 1'b1;
      applyStimulus();  tick();
      data_sram_req = 1'b0;
      applyStimulus();  tick();
      inst_sram_req = 1'b0;  bus_addr_ok = 1'b0;  resetn = 1'b0;
      applyStimulus();  tick();
      resetn = 1'b1;  bus_data_ok = 1'b1;
      applyStimulus();
      checkOutput("rst_discard_idok", inst_sram_data_ok, 1'b0);
      checkOutput("rst_discard_ddok", data_sram_data_ok, 1'b0);
      tick();
      bus_data_ok = 1'b0;

      // Randomized traffic: requesters hold until accepted, downstream is random.
      for (int n = 0; n < 3000; n++) begin
         if (!inst_sram_req || last_iaok) begin
            inst_sram_req  = ($urandom_range(0, 2) != 0);
            inst_sram_size = 2'd2;
            inst_sram_addr = $urandom & 32'hFFFF_FFFC;
         end
         if (!data_sram_req || last_daok) begin
            data_sram_req   = ($urandom_range(0, 2) != 0);
            data_sram_wr    = $urandom_range(0, 1) == 1;
            data_sram_size  = 2'($urandom_range(0, 2));
            data_sram_wstrb = 4'($urandom);
            data_sram_addr  = $urandom;
            data_sram_wdata = $urandom;
         end
         bus_addr_ok = $urandom_range(0, 1) == 1;
         bus_data_ok = (ot_m.size() > 0) ? ($urandom_range(0, 1) == 1)
                                         : ($urandom_range(0, 9) == 0);
         bus_rdata   = $urandom;
         resetn      = ($urandom_range(0, 499) != 0);
         applyStimulus();
         tick();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
